// File: rtl/multi_debounce.sv
// multi_debounce
// ---------------------------------------------------------------------------
// Multi-channel push-button debouncer for a bank of raw board buttons.
// Each channel has its own logic, independent of the other channels:
//   - a 2-flop synchroniser (s0 -> s1),
//   - a STABLE/CHANGED filter with a restart-on-glitch counter,
//   - registered one-cycle rise/fall pulses.
// A channel's output follows its input only after the synchronised input has
// differed from the output for COUNT consecutive cycles. Any cycle where the
// synchronised input matches the output again restarts the count. From an
// input change to the output update is COUNT+2 cycles.
//
// Optional feature (compile-time macro DEBOUNCE_HOLD_EN):
//   Long-press detection. btn_hold[i] rises HOLD_COUNT cycles after the
//   btn_rise[i] cycle. It clears in the same cycle that btn_fall[i] pulses.
//   When the macro is not defined, btn_hold is tied to 0. The port stays in
//   the interface, so instantiations do not change.
//
// Parameters:
//   CHANNELS   number of independent channels (>= 1)
//   COUNT      number of stable cycles of difference needed before the
//              output follows (>= 2)
//   CNT_W      width of the filter counter; 2**CNT_W must be > COUNT
//   HOLD_COUNT number of debounced-high cycles before btn_hold asserts
//
// Ports:
//   clk       system clock; all logic runs on the rising edge
//   reset     synchronous, active-high; clears all state
//   btn_in    raw, asynchronous button levels
//   btn_out   debounced levels
//   btn_rise  one-cycle pulse on the first cycle that btn_out is 1
//   btn_fall  one-cycle pulse on the first cycle that btn_out is 0
//   btn_hold  debounced long-press level (always 0 without DEBOUNCE_HOLD_EN)
//
// Per-channel filter state:
//   Each channel's state is the register g_ch[i].state.
//   1'b0 = STABLE, 1'b1 = CHANGED.
//   Checkers can bind to this register.
// ---------------------------------------------------------------------------
module multi_debounce #(
  parameter int CHANNELS   = 4,
  parameter int COUNT      = 3000000,
  parameter int CNT_W      = 22,
  parameter int HOLD_COUNT = 6000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_out,
  output logic [CHANNELS-1:0] btn_rise,
  output logic [CHANNELS-1:0] btn_fall,
  output logic [CHANNELS-1:0] btn_hold
);

  typedef enum logic {
    STABLE  = 1'b0,
    CHANGED = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(COUNT - 1);

  // Elaboration-time parameter sanity checks.
  if (CHANNELS < 1) begin : g_bad_channels
    $error("multi_debounce: CHANNELS must be >= 1");
  end
  if (COUNT < 2 || (64'(1) << CNT_W) <= 64'(COUNT)) begin : g_bad_count
    $error("multi_debounce: need COUNT >= 2 and 2**CNT_W > COUNT");
  end
  if (HOLD_COUNT < 1 || (64'(1) << (CNT_W + 1)) <= 64'(HOLD_COUNT)) begin : g_bad_hold
    $error("multi_debounce: need HOLD_COUNT >= 1 and 2**(CNT_W+1) > HOLD_COUNT");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic             s0;
    logic             s1;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             out_q;
    logic             rise_q;
    logic             fall_q;
    logic             commit;

    // commit is high on the edge where the output takes the new level:
    // the input has differed from the output for COUNT cycles in a row.
    assign commit = (state == CHANGED) && (s1 != out_q) && (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
      if (reset) begin
        s0     <= 1'b0;
        s1     <= 1'b0;
        state  <= STABLE;
        cnt    <= '0;
        out_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        s0     <= btn_in[i];
        s1     <= s0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        case (state)
          STABLE: begin
            cnt <= '0;
            if (s1 != out_q) begin
              state <= CHANGED;
            end
          end
          CHANGED: begin
            if (s1 == out_q) begin
              // A glitch: the input returned to the output level before the
              // count finished. Drop back to STABLE and do not issue a pulse.
              state <= STABLE;
              cnt   <= '0;
            end else if (commit) begin
              out_q  <= s1;
              state  <= STABLE;
              cnt    <= '0;
              rise_q <= s1;
              fall_q <= ~s1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        endcase
      end
    end

    assign btn_out[i]  = out_q;
    assign btn_rise[i] = rise_q;
    assign btn_fall[i] = fall_q;

`ifdef DEBOUNCE_HOLD_EN
    localparam logic [CNT_W:0] HOLD_MAX = (CNT_W + 1)'(HOLD_COUNT - 1);

    logic [CNT_W:0] hcnt;
    logic           hold_q;

    // On the edge where the output falls, out_q is still 1 and commit is
    // high. Clearing on commit makes btn_hold drop in the same cycle that
    // btn_fall pulses. While out_q is 1, commit can only mean a falling
    // transition.
    always_ff @(posedge clk) begin
      if (reset) begin
        hcnt   <= '0;
        hold_q <= 1'b0;
      end else if (!out_q || commit) begin
        hcnt   <= '0;
        hold_q <= 1'b0;
      end else if (!hold_q) begin
        if (hcnt == HOLD_MAX) begin
          hold_q <= 1'b1;
        end else begin
          hcnt <= hcnt + 1'b1;
        end
      end
    end

    assign btn_hold[i] = hold_q;
`else
    assign btn_hold[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_multi_debounce.sv
// Testbench for multi_debounce with small parameters: COUNT=4, CHANNELS=4,
// HOLD_COUNT=10.
//
// How the bench is organised:
//   - Stimulus drives btn_in on the falling clock edge.
//   - For each debounced edge it expects, stimulus pushes one record into
//     exp_q: {cycle, rise, fall, out}.
//   - A monitor samples on the falling edge. Whenever any rise or fall pulse
//     is present, it pops the next record and compares it.
//   - If an expected event's cycle passes with no pulse, the monitor reports
//     it as missed.
//   - btn_hold and the reset state are checked directly at chosen cycles.
module tb_multi_debounce;

  localparam int CH    = 4;
  localparam int COUNT = 4;
  localparam int CNT_W = 3;
  localparam int HOLD  = 10;
  localparam int LAT   = COUNT + 2;
  localparam int W     = 44;

`ifdef DEBOUNCE_HOLD_EN
  localparam bit HOLD_ON = 1'b1;
`else
  localparam bit HOLD_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CH-1:0] btn_in = '0;
  logic [CH-1:0] btn_out;
  logic [CH-1:0] btn_rise;
  logic [CH-1:0] btn_fall;
  logic [CH-1:0] btn_hold;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [W-1:0] exp_q[$];

  multi_debounce #(
    .CHANNELS(CH),
    .COUNT(COUNT),
    .CNT_W(CNT_W),
    .HOLD_COUNT(HOLD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_in(btn_in),
    .btn_out(btn_out),
    .btn_rise(btn_rise),
    .btn_fall(btn_fall),
    .btn_hold(btn_hold)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Called on a falling edge right after btn_in has been driven. The input
  // is set up before edge cyc+1, so the output changes LAT edges later.
  task automatic expect_event(input logic [CH-1:0] rise, input logic [CH-1:0] fall,
                              input logic [CH-1:0] out);
    exp_q.push_back({32'(cyc + 1 + LAT), rise, fall, out});
  endtask

  function automatic logic [CH-1:0] hold_exp(input logic [CH-1:0] v);
    return HOLD_ON ? v : '0;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] item;
    if (exp_q.size() > 0 && exp_q[0][43:12] < 32'(cyc)) begin
      item = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL missed_event: got no pulse expected rise=%b fall=%b at cycle %0d",
               item[11:8], item[7:4], item[43:12]);
    end
    if ((btn_rise | btn_fall) != '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: got rise=%b fall=%b expected none (cycle %0d)",
                 btn_rise, btn_fall, cyc);
      end else begin
        item = exp_q.pop_front();
        check("evt_cycle", 32'(cyc), item[43:12]);
        check("evt_rise", 32'(btn_rise), 32'(item[11:8]));
        check("evt_fall", 32'(btn_fall), 32'(item[7:4]));
        check("evt_out", 32'(btn_out), 32'(item[3:0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int d;
    int d2;

    // Reset for 3 cycles with all inputs low.
    reset  = 1'b1;
    btn_in = '0;
    wait_n(3);
    reset = 1'b0;
    wait_n(1);
    check("rst_out", 32'(btn_out), 32'(4'b0000));
    check("rst_rise", 32'(btn_rise), 32'(4'b0000));
    check("rst_fall", 32'(btn_fall), 32'(4'b0000));
    check("rst_hold", 32'(btn_hold), 32'(4'b0000));

    // Channel 0 rises. Expect the output and the pulse LAT cycles later.
    btn_in[0] = 1'b1;
    expect_event(4'b0001, 4'b0000, 4'b0001);
    wait_n(10);

    // Channel 1: a 3-cycle glitch must not produce any event.
    btn_in[1] = 1'b1;
    wait_n(3);
    btn_in[1] = 1'b0;
    wait_n(10);

    // Channel 2 bounces 1,0,1,0,1 and then holds at 1.
    btn_in[2] = 1'b1; wait_n(1);
    btn_in[2] = 1'b0; wait_n(1);
    btn_in[2] = 1'b1; wait_n(1);
    btn_in[2] = 1'b0; wait_n(1);
    btn_in[2] = 1'b1;
    expect_event(4'b0100, 4'b0000, 4'b0101);
    wait_n(10);
    check("level_after_bounce", 32'(btn_out), 32'(4'b0101));

    // Channel 0 falls so that it can rise together with channel 3.
    btn_in[0] = 1'b0;
    expect_event(4'b0000, 4'b0001, 4'b0100);
    wait_n(10);

    // Channels 0 and 3 rise in the same cycle. Check btn_hold around the
    // HOLD boundary.
    btn_in[0] = 1'b1;
    btn_in[3] = 1'b1;
    d = cyc;
    expect_event(4'b1001, 4'b0000, 4'b1101);
    wait_until(d + 1 + LAT + HOLD - 1);
    check("hold_before", 32'(btn_hold), 32'(hold_exp(4'b0100)));
    wait_until(d + 1 + LAT + HOLD);
    check("hold_rise", 32'(btn_hold), 32'(hold_exp(4'b1101)));

    // Channel 0 falls. btn_hold[0] clears with btn_fall[0]; channel 3 is unaffected.
    btn_in[0] = 1'b0;
    d2 = cyc;
    expect_event(4'b0000, 4'b0001, 4'b1100);
    wait_until(d2 + LAT);
    check("hold_before_fall", 32'(btn_hold), 32'(hold_exp(4'b1101)));
    wait_until(d2 + LAT + 1);
    check("hold_clear_on_fall", 32'(btn_hold), 32'(hold_exp(4'b1100)));
    wait_n(3);

    // Channel 0 rises, but reset is asserted while its counter is at 2.
    btn_in[0] = 1'b1;
    d = cyc;
    wait_until(d + 5);
    reset = 1'b1;
    wait_n(2);
    check("midrst_out", 32'(btn_out), 32'(4'b0000));
    check("midrst_rise", 32'(btn_rise), 32'(4'b0000));
    check("midrst_fall", 32'(btn_fall), 32'(4'b0000));
    check("midrst_hold", 32'(btn_hold), 32'(4'b0000));
    reset = 1'b0;
    // The inputs held through reset debounce again from zero.
    expect_event(4'b1101, 4'b0000, 4'b1101);
    wait_n(12);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_out", 32'(btn_out), 32'(4'b1101));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
